// File: rtl/dual_gray_pkg.sv
// Shared types and Gray decode rule for the dual Gray counter checker.
// No logic of its own; consumed by gray_to_bin and dual_gray_checker.
// Not applicable: no flow control.
package dual_gray_pkg;

    localparam int G4_W = 4;
    localparam int G3_W = 3;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Decode of a w-bit Gray value held in the low bits of g: each binary bit
    // is the XOR of its own and all higher Gray bits within the width.
    function automatic logic [G4_W-1:0] gray2bin(input logic [G4_W-1:0] g, input int w);
        logic [G4_W-1:0] gm;
        logic [G4_W-1:0] b;
        gm = g & G4_W'((1 << w) - 1);
        b  = '0;
        for (int i = 0; i < G4_W; i++) begin
            b[i] = (i < w) ? ^(gm >> i) : 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/dual_gray_checker_gray_to_bin.sv
// Combinational W-bit Gray to binary decoder.
// Latency: zero cycles.
// Backpressure: none, purely combinational.
module gray_to_bin
    import dual_gray_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin = W'(gray2bin(G4_W'(gray), W));

endmodule

// File: rtl/dual_gray_checker.sv
// Integrity monitor for a dual 4-bit/3-bit Gray count stream: step check, lock FSM, error count.
// Latency: sample accepted at edge N is reflected on all outputs right after edge N.
// Backpressure: none; en qualifies samples and idle cycles simply hold state.
module dual_gray_checker
    import dual_gray_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       gray_4,
    input  logic [2:0]       gray_3,
    output logic [3:0]       bin_4,
    output logic [2:0]       bin_3,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap_4,
    output logic             wrap_3
);

    localparam int CNT_W = $clog2(LOCK_CNT + 1);

    logic [G4_W-1:0]  dec_4;
    logic [G3_W-1:0]  dec_3;
    logic [G4_W-1:0]  nxt_4;
    logic [G3_W-1:0]  nxt_3;
    logic             step_good;
    logic             have_prev;
    logic [CNT_W-1:0] good_cnt;
    state_t           state;

    gray_to_bin #(.W(G4_W)) u_dec_4 (.gray(gray_4), .bin(dec_4));
    gray_to_bin #(.W(G3_W)) u_dec_3 (.gray(gray_3), .bin(dec_3));

    assign nxt_4 = bin_4 + 1'b1;
    assign nxt_3 = bin_3 + 1'b1;

    // Both channels must advance by one and stay phase-aligned.
    assign step_good = (dec_4 == nxt_4) && (dec_3 == nxt_3) && (dec_3 == dec_4[G3_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_4     <= '0;
            bin_3     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            wrap_4    <= 1'b0;
            wrap_3    <= 1'b0;
            have_prev <= 1'b0;
            good_cnt  <= '0;
            state     <= UNLOCKED;
        end else begin
            err_pulse <= 1'b0;
            wrap_4    <= 1'b0;
            wrap_3    <= 1'b0;
            if (en) begin
                bin_4     <= dec_4;
                bin_3     <= dec_3;
                have_prev <= 1'b1;
                if (have_prev) begin
                    if (step_good) begin
                        wrap_4 <= (dec_4 == '0);
                        wrap_3 <= (dec_3 == '0);
                        if (state == UNLOCKED) begin
                            if (good_cnt == CNT_W'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end
                    end else begin
                        good_cnt <= '0;
                        if (state == LOCKED) begin
                            err_pulse <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                            state  <= UNLOCKED;
                            locked <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_gray_checker.sv
// Directed vector bench for dual_gray_checker (LOCK_CNT=3, ERR_W=2).
module tb_dual_gray_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] gray_4 = '0;
    logic [2:0] gray_3 = '0;
    logic [3:0] bin_4;
    logic [2:0] bin_3;
    logic       locked;
    logic       err_pulse;
    logic [1:0] err_count;
    logic       wrap_4;
    logic       wrap_3;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] g4;
        logic [2:0] g3;
        logic [3:0] b4;
        logic [2:0] b3;
        logic       lk;
        logic       ep;
        logic [1:0] ec;
        logic       w4;
        logic       w3;
    } vec_t;

    vec_t vq[$];

    dual_gray_checker #(.LOCK_CNT(3), .ERR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .gray_4    (gray_4),
        .gray_3    (gray_3),
        .bin_4     (bin_4),
        .bin_3     (bin_3),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .wrap_4    (wrap_4),
        .wrap_3    (wrap_3)
    );

    always #5 clk = ~clk;

    // Binary-to-Gray encoders play the role of the transmitting counter.
    function automatic logic [3:0] enc4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [2:0] enc3(input int b);
        logic [2:0] x;
        x = 3'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic add(input int rst, input int e, input logic [3:0] g4, input logic [2:0] g3,
                       input int b4, input int b3, input int lk, input int ep, input int ec,
                       input int w4, input int w3);
        vec_t v;
        v.rst = 1'(rst); v.en = 1'(e); v.g4 = g4; v.g3 = g3;
        v.b4 = 4'(b4); v.b3 = 3'(b3); v.lk = 1'(lk); v.ep = 1'(ep);
        v.ec = 2'(ec); v.w4 = 1'(w4); v.w3 = 1'(w3);
        vq.push_back(v);
    endtask

    // Accepted sample whose binary value is b4/b3; bin outputs must show it.
    task automatic smp(input int b4, input int b3, input int lk, input int ep, input int ec,
                       input int w4, input int w3);
        add(0, 1, enc4(b4), enc3(b3), b4, b3, lk, ep, ec, w4, w3);
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at vector %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input vec_t v);
        chk("bin_4",     idx, 8'(bin_4),     8'(v.b4));
        chk("bin_3",     idx, 8'(bin_3),     8'(v.b3));
        chk("locked",    idx, 8'(locked),    8'(v.lk));
        chk("err_pulse", idx, 8'(err_pulse), 8'(v.ep));
        chk("err_count", idx, 8'(err_count), 8'(v.ec));
        chk("wrap_4",    idx, 8'(wrap_4),    8'(v.w4));
        chk("wrap_3",    idx, 8'(wrap_3),    8'(v.w3));
    endtask

    initial begin
        // Lock acquisition
        add(1, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        smp(0, 0, 0, 0, 0, 0, 0);
        smp(1, 1, 0, 0, 0, 0, 0);
        smp(2, 2, 0, 0, 0, 0, 0);
        smp(3, 3, 1, 0, 0, 0, 0);
        // Sixteen further locked samples through the 15->0 wrap
        for (int k = 4; k < 20; k++) begin
            smp(k % 16, k % 8, 1, 0, 0, int'(k % 16 == 0), int'(k % 8 == 0));
        end
        smp(4, 4, 1, 0, 0, 0, 0);
        // Corrupted gray_4 (decodes to 4 again), then relock
        add(0, 1, 4'b0110, enc3(4), 4, 4, 0, 1, 1, 0, 0);
        smp(5, 5, 0, 0, 1, 0, 0);
        smp(6, 6, 0, 0, 1, 0, 0);
        smp(7, 7, 1, 0, 1, 0, 0);
        // Idle window with garbage on the inputs
        for (int k = 0; k < 5; k++) add(0, 0, 4'b1111, 3'b101, 7, 7, 1, 0, 1, 0, 0);
        smp(8, 0, 1, 0, 1, 0, 1);
        smp(8, 0, 0, 1, 2, 0, 0);
        add(0, 0, 4'b0000, 3'b000, 8, 0, 0, 0, 2, 0, 0);
        smp(9, 1, 0, 0, 2, 0, 0);
        smp(10, 2, 0, 0, 2, 0, 0);
        smp(11, 3, 1, 0, 2, 0, 0);
        // Mid-stream reset with en high, then fresh capture
        add(1, 1, enc4(12), enc3(4), 0, 0, 0, 0, 0, 0, 0);
        smp(12, 4, 0, 0, 0, 0, 0);
        smp(13, 5, 0, 0, 0, 0, 0);
        smp(14, 6, 0, 0, 0, 0, 0);
        smp(15, 7, 1, 0, 0, 0, 0);
        // Phase skew: gray_3 one step ahead, never locks, never counts
        add(1, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) smp(k, (k + 1) % 8, 0, 0, 0, 0, 0);
        // Saturation: five errors, each followed by a relock
        add(1, 0, 4'b0000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        smp(0, 0, 0, 0, 0, 0, 0);
        smp(1, 1, 0, 0, 0, 0, 0);
        smp(2, 2, 0, 0, 0, 0, 0);
        smp(3, 3, 1, 0, 0, 0, 0);
        smp(3, 3, 0, 1, 1, 0, 0);
        smp(4, 4, 0, 0, 1, 0, 0);
        smp(5, 5, 0, 0, 1, 0, 0);
        smp(6, 6, 1, 0, 1, 0, 0);
        smp(6, 6, 0, 1, 2, 0, 0);
        smp(7, 7, 0, 0, 2, 0, 0);
        smp(8, 0, 0, 0, 2, 0, 1);
        smp(9, 1, 1, 0, 2, 0, 0);
        smp(11, 3, 0, 1, 3, 0, 0);
        smp(12, 4, 0, 0, 3, 0, 0);
        smp(13, 5, 0, 0, 3, 0, 0);
        smp(14, 6, 1, 0, 3, 0, 0);
        smp(14, 6, 0, 1, 3, 0, 0);
        smp(15, 7, 0, 0, 3, 0, 0);
        smp(0, 0, 0, 0, 3, 1, 1);
        smp(1, 1, 1, 0, 3, 0, 0);
        smp(1, 1, 0, 1, 3, 0, 0);
        smp(2, 2, 0, 0, 3, 0, 0);
        smp(3, 3, 0, 0, 3, 0, 0);
        smp(4, 4, 1, 0, 3, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            reset  = vq[i].rst;
            en     = vq[i].en;
            gray_4 = vq[i].g4;
            gray_3 = vq[i].g3;
            @(posedge clk);
            #1;
            n_vec++;
            check_outs(i, vq[i]);
        end

        // Saturated and locked: idle cycles hold everything, then one more good step
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            reset = 1'b0; en = 1'b0; gray_4 = 4'b1010; gray_3 = 3'b011;
            @(posedge clk);
            #1;
            n_vec++;
            chk("hold_bin_4",     1000 + c, 8'(bin_4),     8'd4);
            chk("hold_locked",    1000 + c, 8'(locked),    8'd1);
            chk("hold_err_pulse", 1000 + c, 8'(err_pulse), 8'd0);
            chk("hold_err_count", 1000 + c, 8'(err_count), 8'd3);
        end
        @(negedge clk);
        en = 1'b1; gray_4 = 4'b0111; gray_3 = 3'b111;
        @(posedge clk);
        #1;
        n_vec++;
        chk("post_bin_4",     1003, 8'(bin_4),     8'd5);
        chk("post_bin_3",     1003, 8'(bin_3),     8'd5);
        chk("post_locked",    1003, 8'(locked),    8'd1);
        chk("post_err_count", 1003, 8'(err_count), 8'd3);
        @(negedge clk);
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
